// File: rtl/bnn_cfg_regbank.sv
// rtl/bnn_cfg_regbank.sv - APB config/status bank: shadow/active BNN weights, commit FSM, result FIFO
// Optional registered interrupt output enabled by defining BNN_CFG_IRQ_EN.
module bnn_cfg_regbank #(
  parameter int N_CONV    = 3,
  parameter int CONV_W    = 5,
  parameter int N_FC      = 2,
  parameter int FC_BITS   = 108,
  parameter int RES_W     = 2,
  parameter int RES_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [11:0]              paddr,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [31:0]              pwdata,
  output logic [31:0]              prdata,
  output logic                     pready,
  output logic                     pslverr,
  input  logic                     bnn_busy,
  input  logic                     vad_duration,
  input  logic                     res_valid,
  input  logic [RES_W-1:0]         res_data,
  output logic [N_CONV*CONV_W-1:0] conv_wt,
  output logic [N_FC*FC_BITS-1:0]  fc_wt,
  output logic                     mfcc_wr_en,
  output logic                     commit_done,
  output logic                     irq
);

  localparam int FC_WORDS = (FC_BITS + 31) / 32;
  localparam int FC_PAD   = FC_WORDS * 32;
  localparam int PW       = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CW       = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RES_DEPTH);

  typedef enum logic {IDLE, PEND} state_t;
  state_t state_q, state_d;

  function automatic logic [31:0] word_mask(input int k);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 32; b++) m[b] = ((k * 32 + b) < FC_BITS);
    return m;
  endfunction

  logic access, wr, rd;
  logic sel_ctrl, sel_status, sel_result, sel_conv, sel_fc, mapped;
  logic [5:0] conv_i, fc_j;
  logic [3:0] fc_k;
  logic ctrl_wr, commit_req, fifo_clr, load;
  logic unused_addr_lsb;

  assign access = psel & penable;
  assign wr     = access & pwrite;
  assign rd     = access & ~pwrite;

  assign sel_ctrl   = (paddr[11:2] == 10'd0);
  assign sel_status = (paddr[11:2] == 10'd1);
  assign sel_result = (paddr[11:2] == 10'd2);
  assign conv_i     = paddr[7:2];
  assign sel_conv   = (paddr[11:8] == 4'h1) && (conv_i < 6'(N_CONV));
  assign fc_j       = paddr[11:6] - 6'd8;
  assign fc_k       = paddr[5:2];
  assign sel_fc     = (paddr[11:9] == 3'b001) && (fc_j < 6'(N_FC)) && ({1'b0, fc_k} < 5'(FC_WORDS));
  assign mapped     = sel_ctrl | sel_status | sel_result | sel_conv | sel_fc;
  assign unused_addr_lsb = ^paddr[1:0];

  assign pready  = 1'b1;
  assign pslverr = access & (~mapped | (pwrite & (sel_status | sel_result)));

  assign ctrl_wr    = wr & sel_ctrl;
  assign commit_req = ctrl_wr & pwdata[1];
  assign fifo_clr   = ctrl_wr & pwdata[2];

  // Shadow FC words are padded to whole 32-bit words; bits past FC_BITS stay 0.
  logic [N_CONV*CONV_W-1:0] conv_sh;
  logic [N_FC*FC_PAD-1:0]   fc_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      conv_sh    <= '0;
      fc_sh      <= '0;
      mfcc_wr_en <= 1'b0;
    end else begin
      if (ctrl_wr) mfcc_wr_en <= pwdata[0];
      for (int i = 0; i < N_CONV; i++)
        if (wr && sel_conv && conv_i == 6'(i))
          conv_sh[i*CONV_W +: CONV_W] <= pwdata[CONV_W-1:0];
      for (int j = 0; j < N_FC; j++)
        for (int k = 0; k < FC_WORDS; k++)
          if (wr && sel_fc && fc_j == 6'(j) && fc_k == 4'(k))
            fc_sh[j*FC_PAD + k*32 +: 32] <= pwdata & word_mask(k);
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: if (commit_req) begin
        if (bnn_busy) state_d = PEND;
        else          load    = 1'b1;
      end
      PEND: if (!bnn_busy) begin
        load    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      commit_done <= 1'b0;
      conv_wt     <= '0;
      fc_wt       <= '0;
    end else begin
      state_q     <= state_d;
      commit_done <= load;
      if (load) begin
        conv_wt <= conv_sh;
        for (int j = 0; j < N_FC; j++)
          fc_wt[j*FC_BITS +: FC_BITS] <= fc_sh[j*FC_PAD +: FC_BITS];
      end
    end
  end

  // Result FIFO; a full FIFO still accepts a push when the head leaves in the same cycle.
  logic [RES_W-1:0] fifo_mem [RES_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             overflow, fifo_empty, fifo_full, push, pop;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign pop        = rd & sel_result & ~fifo_empty;
  assign push       = res_valid & ~fifo_clr & (~fifo_full | pop);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= res_data;
  end

  always_ff @(posedge clk) begin
    if (rst || fifo_clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (res_valid && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  logic irq_en_q;
`ifdef BNN_CFG_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= pwdata[3];
      irq <= irq_en_q & (~fifo_empty | overflow);
    end
  end
`else
  assign irq_en_q = 1'b0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    prdata = '0;
    if (rd) begin
      if (sel_ctrl) begin
        prdata[0] = mfcc_wr_en;
        prdata[3] = irq_en_q;
      end
      if (sel_status) begin
        prdata[0]    = (state_q == PEND);
        prdata[1]    = fifo_empty;
        prdata[2]    = fifo_full;
        prdata[3]    = overflow;
        prdata[4]    = vad_duration;
        prdata[12:8] = 5'(count);
      end
      if (sel_result && !fifo_empty) begin
        prdata[31]        = 1'b1;
        prdata[RES_W-1:0] = fifo_mem[rd_ptr];
      end
      for (int i = 0; i < N_CONV; i++)
        if (sel_conv && conv_i == 6'(i))
          prdata[CONV_W-1:0] = conv_sh[i*CONV_W +: CONV_W];
      for (int j = 0; j < N_FC; j++)
        for (int k = 0; k < FC_WORDS; k++)
          if (sel_fc && fc_j == 6'(j) && fc_k == 4'(k))
            prdata = fc_sh[j*FC_PAD + k*32 +: 32];
    end
  end

endmodule

// File: tb/tb_bnn_cfg_regbank.sv
// tb/tb_bnn_cfg_regbank.sv - self-checking bench for bnn_cfg_regbank
module tb_bnn_cfg_regbank;
  localparam int N_CONV = 3, CONV_W = 5, N_FC = 2, FC_BITS = 108, RES_W = 2, RES_DEPTH = 4;
  localparam int FC_WORDS = (FC_BITS + 31) / 32;
`ifdef BNN_CFG_IRQ_EN
  localparam bit IRQ_BUILT = 1'b1;
  localparam logic [31:0] CTRL_RB = 32'h9;
`else
  localparam bit IRQ_BUILT = 1'b0;
  localparam logic [31:0] CTRL_RB = 32'h1;
`endif

  logic clk = 1'b0;
  logic rst, psel, penable, pwrite, bnn_busy, vad_duration, res_valid;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic pready, pslverr, mfcc_wr_en, commit_done, irq;
  logic [RES_W-1:0] res_data;
  logic [N_CONV*CONV_W-1:0] conv_wt;
  logic [N_FC*FC_BITS-1:0] fc_wt;

  always #5 clk = ~clk;

  bnn_cfg_regbank #(.N_CONV(N_CONV), .CONV_W(CONV_W), .N_FC(N_FC), .FC_BITS(FC_BITS),
                    .RES_W(RES_W), .RES_DEPTH(RES_DEPTH)) dut (
    .clk(clk), .rst(rst), .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .bnn_busy(bnn_busy), .vad_duration(vad_duration), .res_valid(res_valid), .res_data(res_data),
    .conv_wt(conv_wt), .fc_wt(fc_wt), .mfcc_wr_en(mfcc_wr_en), .commit_done(commit_done), .irq(irq));

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: plain arrays and a queue describing the register map behaviour.
  int          m_conv_sh [N_CONV], m_conv_act [N_CONV];
  logic [31:0] m_fc_sh [N_FC][FC_WORDS], m_fc_act [N_FC][FC_WORDS];
  int          m_q [$];
  bit          m_ovf, m_pend, m_mfcc, m_irqen;

  task automatic model_reset();
    for (int i = 0; i < N_CONV; i++) begin m_conv_sh[i] = 0; m_conv_act[i] = 0; end
    for (int j = 0; j < N_FC; j++)
      for (int k = 0; k < FC_WORDS; k++) begin m_fc_sh[j][k] = 0; m_fc_act[j][k] = 0; end
    m_q.delete();
    m_ovf = 0; m_pend = 0; m_mfcc = 0; m_irqen = 0;
  endtask

  task automatic model_load();
    m_conv_act = m_conv_sh;
    m_fc_act   = m_fc_sh;
  endtask

  function automatic logic [31:0] fc_mask(input int k);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 32; b++) if (k * 32 + b < FC_BITS) m[b] = 1'b1;
    return m;
  endfunction

  function automatic bit is_mapped(input int a);
    int off;
    off = a - 'h200;
    if (a == 0 || a == 4 || a == 8) return 1;
    if (a >= 'h100 && a < 'h100 + 4 * N_CONV) return 1;
    if (a >= 'h200 && a < 'h200 + 'h40 * N_FC && (off % 'h40) < 4 * FC_WORDS) return 1;
    return 0;
  endfunction

  function automatic bit exp_err(input int a, input bit w);
    int aa;
    aa = a & ~3;
    return !is_mapped(aa) || (w && (aa == 4 || aa == 8));
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[0] = m_pend;
    s[1] = (m_q.size() == 0);
    s[2] = (m_q.size() == RES_DEPTH);
    s[3] = m_ovf;
    s[4] = vad_duration;
    s[12:8] = 5'(m_q.size());
    return s;
  endfunction

  function automatic logic [255:0] exp_conv();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < N_CONV; i++)
      v = v | (256'(m_conv_act[i] & ((1 << CONV_W) - 1)) << (i * CONV_W));
    return v;
  endfunction

  function automatic logic [255:0] exp_fc();
    logic [255:0] v;
    v = '0;
    for (int j = 0; j < N_FC; j++)
      for (int k = 0; k < FC_WORDS; k++)
        v = v | (256'(m_fc_act[j][k]) << (j * FC_BITS + k * 32));
    return v;
  endfunction

  task automatic model_write(input int a, input logic [31:0] d);
    int aa;
    aa = a & ~3;
    if (exp_err(aa, 1)) return;
    if (aa == 0) begin
      m_mfcc  = d[0];
      m_irqen = d[3] & IRQ_BUILT;
      if (d[2]) begin m_q.delete(); m_ovf = 0; end
      if (d[1] && !m_pend) begin
        if (bnn_busy) m_pend = 1;
        else model_load();
      end
    end else if (aa < 'h200) begin
      m_conv_sh[(aa - 'h100) / 4] = int'(d) & ((1 << CONV_W) - 1);
    end else begin
      m_fc_sh[(aa - 'h200) / 'h40][((aa - 'h200) % 'h40) / 4] = d & fc_mask(((aa - 'h200) % 'h40) / 4);
    end
  endtask

  task automatic model_read(input int a, output logic [31:0] v);
    int aa;
    aa = a & ~3;
    v = '0;
    if (exp_err(aa, 0)) return;
    if (aa == 0) begin v[0] = m_mfcc; v[3] = m_irqen; end
    else if (aa == 4) v = exp_status();
    else if (aa == 8) begin
      if (m_q.size() != 0) begin v = 32'h8000_0000 | 32'(m_q[0]); void'(m_q.pop_front()); end
    end
    else if (aa < 'h200) v = 32'(m_conv_sh[(aa - 'h100) / 4]);
    else v = m_fc_sh[(aa - 'h200) / 'h40][((aa - 'h200) % 'h40) / 4];
  endtask

  task automatic model_push(input int d);
    if (m_q.size() < RES_DEPTH) m_q.push_back(d);
    else m_ovf = 1;
  endtask

  // One APB transfer, called and returning at a negedge with the bus idle.
  task automatic apb(input logic [11:0] a, input logic [31:0] d, input bit w, input bit push_also,
                     input logic [RES_W-1:0] pd, output logic [31:0] rdat, output logic err);
    paddr = a; pwdata = d; pwrite = w; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    if (push_also) begin res_valid = 1'b1; res_data = pd; end
    #1;
    rdat = prdata;
    err  = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; res_valid = 1'b0;
  endtask

  task automatic do_write(input int a, input logic [31:0] d);
    logic [31:0] r;
    logic e;
    apb(12'(a), d, 1'b1, 1'b0, '0, r, e);
    chk($sformatf("wr_err@%0h", a), 256'(e), 256'(exp_err(a, 1)));
    model_write(a, d);
  endtask

  task automatic do_read(input int a);
    logic [31:0] r, x;
    logic e, ee;
    ee = exp_err(a, 0);
    model_read(a, x);
    apb(12'(a), '0, 1'b0, 1'b0, '0, r, e);
    chk($sformatf("rd_data@%0h", a), 256'(r), 256'(x));
    chk($sformatf("rd_err@%0h", a), 256'(e), 256'(ee));
  endtask

  task automatic pulse(input logic [RES_W-1:0] d);
    res_valid = 1'b1; res_data = d;
    @(negedge clk);
    res_valid = 1'b0;
    model_push(int'(d));
  endtask

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
    bit          w;
    logic [31:0] exp_rd;
    bit          exp_e;
  } vec_t;

  vec_t tbl [$];
  logic [31:0] r;
  logic e;
  int i, j, k, op;

  initial begin
    tbl = '{
      '{12'h000, 32'h0,        0, 32'h0,        0},
      '{12'h004, 32'h0,        0, 32'h2,        0},
      '{12'h100, 32'h15,       1, 32'h0,        0},
      '{12'h104, 32'hFFFFFFEA, 1, 32'h0,        0},
      '{12'h108, 32'h1F,       1, 32'h0,        0},
      '{12'h100, 32'h0,        0, 32'h15,       0},
      '{12'h104, 32'h0,        0, 32'h0A,       0},
      '{12'h10B, 32'h0,        0, 32'h1F,       0},
      '{12'h10C, 32'h0,        0, 32'h0,        1},
      '{12'h00C, 32'h0,        0, 32'h0,        1},
      '{12'h004, 32'h12345678, 1, 32'h0,        1},
      '{12'h008, 32'h1,        1, 32'h0,        1},
      '{12'h004, 32'h0,        0, 32'h2,        0},
      '{12'h200, 32'h12345678, 1, 32'h0,        0},
      '{12'h200, 32'h0,        0, 32'h12345678, 0},
      '{12'h20C, 32'hFFFFFFFF, 1, 32'h0,        0},
      '{12'h20C, 32'h0,        0, 32'h00000FFF, 0},
      '{12'h210, 32'h0,        0, 32'h0,        1},
      '{12'h2C0, 32'h1,        1, 32'h0,        1},
      '{12'h280, 32'h0,        0, 32'h0,        1},
      '{12'h000, 32'h9,        1, 32'h0,        0},
      '{12'h000, 32'h0,        0, CTRL_RB,      0},
      '{12'h008, 32'h0,        0, 32'h0,        0},
      '{12'h000, 32'h0,        1, 32'h0,        0},
      '{12'h000, 32'h0,        0, 32'h0,        0}
    };

    rst = 1'b1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    bnn_busy = 0; vad_duration = 0; res_valid = 0; res_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_pready", 256'(pready), 256'(1));
    chk("rst_conv", 256'(conv_wt), 256'(0));
    chk("rst_fc", 256'(fc_wt), 256'(0));
    chk("rst_outs", 256'({prdata, pslverr, mfcc_wr_en, commit_done, irq}), 256'(0));

    foreach (tbl[n]) begin
      apb(tbl[n].a, tbl[n].d, tbl[n].w, 1'b0, '0, r, e);
      chk($sformatf("tbl%0d_err", n), 256'(e), 256'(tbl[n].exp_e));
      if (!tbl[n].w) chk($sformatf("tbl%0d_rd", n), 256'(r), 256'(tbl[n].exp_rd));
      if (tbl[n].w) model_write(int'(tbl[n].a), tbl[n].d);
      else model_read(int'(tbl[n].a), r);
      chk($sformatf("tbl%0d_mfcc", n), 256'(mfcc_wr_en), 256'(m_mfcc));
    end

    // Idle commit
    do_write('h000, 32'h2);
    chk("commit_done_idle", 256'(commit_done), 256'(1));
    chk("conv_7d55", 256'(conv_wt), 256'(15'h7D55));
    chk("fc_after_commit", 256'(fc_wt), exp_fc());
    @(negedge clk);
    chk("commit_done_pulse", 256'(commit_done), 256'(0));

    // Busy commit goes pending; shadow writes while pending are included
    do_write('h24C, 32'hFFFFFFFF);
    bnn_busy = 1'b1;
    do_write('h000, 32'h2);
    do_read('h004);
    chk("fc_held", 256'(fc_wt), exp_fc());
    do_write('h100, 32'h3);
    do_write('h000, 32'h2);
    repeat (2) @(negedge clk);
    chk("no_done_while_busy", 256'(commit_done), 256'(0));
    chk("conv_held", 256'(conv_wt), exp_conv());
    bnn_busy = 1'b0;
    @(negedge clk);
    model_load(); m_pend = 0;
    chk("commit_done_pend", 256'(commit_done), 256'(1));
    chk("fc_top_fff", 256'(fc_wt[215:204]), 256'(12'hFFF));
    chk("fc_after_pend", 256'(fc_wt), exp_fc());
    chk("conv_after_pend", 256'(conv_wt), exp_conv());
    do_read('h004);

    // Overflow and drain
    pulse(2'd1); pulse(2'd2); pulse(2'd3); pulse(2'd0); pulse(2'd1);
    apb(12'h004, '0, 1'b0, 1'b0, '0, r, e);
    chk("status_full_ovf", 256'(r), 256'(32'h40C));
    chk("res0", 256'(m_q.size()), 256'(4));
    foreach (tbl[n]) if (n < 5) begin
      apb(12'h008, '0, 1'b0, 1'b0, '0, r, e);
      case (n)
        0: chk("pop1", 256'(r), 256'(32'h80000001));
        1: chk("pop2", 256'(r), 256'(32'h80000002));
        2: chk("pop3", 256'(r), 256'(32'h80000003));
        3: chk("pop4", 256'(r), 256'(32'h80000000));
        default: chk("pop_empty", 256'(r), 256'(0));
      endcase
    end
    m_q.delete();

    // Full FIFO: push and pop in the same cycle
    pulse(2'd2); pulse(2'd1); pulse(2'd0); pulse(2'd3);
    apb(12'h008, '0, 1'b0, 1'b1, 2'd1, r, e);
    chk("pushpop_data", 256'(r), 256'(32'h80000002));
    void'(m_q.pop_front()); m_q.push_back(1);
    apb(12'h004, '0, 1'b0, 1'b0, '0, r, e);
    chk("pushpop_status", 256'(r), 256'(32'h40C));
    do_read('h008);

    // Clear with a simultaneous push drops the push
    apb(12'h000, 32'h4, 1'b1, 1'b1, 2'd3, r, e);
    model_write('h000, 32'h4);
    apb(12'h004, '0, 1'b0, 1'b0, '0, r, e);
    chk("clr_status", 256'(r), 256'(32'h2));

    // Reset while pending aborts the commit
    bnn_busy = 1'b1;
    do_write('h100, 32'h7);
    do_write('h000, 32'h2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    bnn_busy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstpend_conv", 256'(conv_wt), 256'(0));
    chk("rstpend_done", 256'(commit_done), 256'(0));
    do_read('h004);
    do_read('h100);

    // Randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      op = $urandom_range(0, 7);
      vad_duration = 1'($urandom_range(0, 1));
      case (op)
        0: begin i = $urandom_range(0, N_CONV - 1); do_write('h100 + 4 * i, $urandom); end
        1: begin
          j = $urandom_range(0, N_FC - 1); k = $urandom_range(0, FC_WORDS - 1);
          do_write('h200 + 'h40 * j + 4 * k, $urandom);
        end
        2: begin
          if ($urandom_range(0, 1)) do_read('h100 + 4 * $urandom_range(0, N_CONV - 1));
          else do_read('h200 + 'h40 * $urandom_range(0, N_FC - 1) + 4 * $urandom_range(0, FC_WORDS - 1));
        end
        3: pulse(RES_W'($urandom));
        4: do_read('h008);
        5: do_read('h004);
        6: begin
          bnn_busy = 1'($urandom_range(0, 1));
          do_write('h000, 32'h2);
          if (bnn_busy) begin
            do_read('h004);
            if ($urandom_range(0, 1)) do_write('h100 + 4 * $urandom_range(0, N_CONV - 1), $urandom);
            chk("rnd_no_done", 256'(commit_done), 256'(0));
            bnn_busy = 1'b0;
            @(negedge clk);
            model_load(); m_pend = 0;
          end
          chk("rnd_done", 256'(commit_done), 256'(1));
          chk("rnd_conv", 256'(conv_wt), exp_conv());
          chk("rnd_fc", 256'(fc_wt), exp_fc());
          @(negedge clk);
          chk("rnd_done_low", 256'(commit_done), 256'(0));
        end
        default: begin
          i = $urandom_range(0, 4095);
          if (!is_mapped(i & ~3)) begin
            if ($urandom_range(0, 1)) do_read(i);
            else do_write(i, $urandom);
          end else do_read('h000);
        end
      endcase
    end
    chk("rnd_final_conv", 256'(conv_wt), exp_conv());
    do_read('h004);

    // Interrupt behaviour
    do_write('h000, 32'hC);
    pulse(2'd2);
    chk("irq_lag", 256'(irq), 256'(0));
    @(negedge clk);
    chk("irq_set", 256'(irq), 256'(IRQ_BUILT));
    do_read('h008);
    @(negedge clk);
    chk("irq_clear", 256'(irq), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
